accumulate_sat_log: RTL and testbench

//  Downstream consumer of the power-of-two multiply stage in the FIR datapath.

---
 rtl/filt_pkg.sv | 21 ++
 rtl/sat_clip.sv | 24 ++
 rtl/accumulate_sat_log.sv | 99 +++++++++
 tb/tb_accumulate_sat_log.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/filt_pkg.sv
// Shared fixed-point definitions for the FIR filter datapath stages.
// Defaults describe the standard Q5.20 sample, 8-tap section.
package filt_pkg;

    localparam int FILT_H    = 5;
    localparam int FILT_W    = 20;
    localparam int FILT_TAPS = 8;
    localparam int FILT_G    = $clog2(FILT_TAPS);
    localparam int FILT_DW   = FILT_H + FILT_W;
    localparam int FILT_AW   = FILT_DW + FILT_G;

    localparam logic signed [FILT_DW-1:0] FX_MAX = {1'b0, {(FILT_DW-1){1'b1}}};
    localparam logic signed [FILT_DW-1:0] FX_MIN = {1'b1, {(FILT_DW-1){1'b0}}};

    typedef logic signed [FILT_AW-1:0] acc_t;

    function automatic acc_t sext_acc(input logic signed [FILT_DW-1:0] d);
        return acc_t'(d);
    endfunction

endpackage

// File: rtl/sat_clip.sv
// Combinational saturating narrowing of a guard-extended sum.
// Shared by the filter stages that reduce accumulator width.
module sat_clip #(
    parameter int DW = 25,
    parameter int AW = 28
) (
    input  logic [AW-1:0] sum_i,
    output logic [DW-1:0] data_o,
    output logic          ovf_o
);

    logic [AW-DW:0] hi;

    // In range only when the guard bits all copy the output sign bit.
    assign hi    = sum_i[AW-1:DW-1];
    assign ovf_o = !((&hi) || (~|hi));

    always_comb begin
        data_o = sum_i[DW-1:0];
        if (ovf_o)
            data_o = {sum_i[AW-1], {(DW-1){~sum_i[AW-1]}}};
    end

endmodule

// File: rtl/accumulate_sat_log.sv
// Frame accumulator: sums tap_num enabled products, emits one clipped sample.
// Define ACCUM_SAT_EN for saturation/ovf_o; otherwise the output wraps.
module accumulate_sat_log
    import filt_pkg::*;
#(
    parameter int width_H = FILT_H,
    parameter int width_W = FILT_W,
    parameter int tap_num = FILT_TAPS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sync_i,
    input  logic                       data_i_en,
    input  logic [width_H+width_W-1:0] data_i,
    output logic                       data_o_en,
    output logic [width_H+width_W-1:0] data_o,
    output logic                       ovf_o
);

    localparam int width_G = $clog2(tap_num);
    localparam int DW      = width_H + width_W;
    localparam int AW      = DW + width_G;
    localparam int CW      = width_G;

    logic [CW-1:0]        cnt_q, cnt_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic                 en_q, en_d;
    logic [DW-1:0]        dat_q, dat_d;
    logic                 ovf_q, ovf_d;

    logic signed [AW-1:0] din_x;
    logic signed [AW-1:0] sum;
    logic                 last;
    logic [DW-1:0]        clip_data;
    logic                 clip_ovf;

    assign din_x = AW'($signed(data_i));
    assign sum   = acc_q + din_x;
    assign last  = data_i_en && !sync_i && (cnt_q == CW'(tap_num - 1));

`ifdef ACCUM_SAT_EN
    sat_clip #(
        .DW(DW),
        .AW(AW)
    ) u_clip (
        .sum_i (sum),
        .data_o(clip_data),
        .ovf_o (clip_ovf)
    );
`else
    assign clip_data = sum[DW-1:0];
    assign clip_ovf  = 1'b0;
`endif

    always_comb begin
        cnt_d = cnt_q;
        acc_d = acc_q;
        en_d  = 1'b0;
        dat_d = dat_q;
        ovf_d = 1'b0;
        if (sync_i) begin
            cnt_d = '0;
            if (data_i_en) begin
                acc_d = din_x;
                cnt_d = CW'(1);
            end
        end else if (data_i_en) begin
            acc_d = (cnt_q == '0) ? din_x : sum;
            cnt_d = cnt_q + CW'(1);
            if (last) begin
                cnt_d = '0;
                en_d  = 1'b1;
                dat_d = clip_data;
                ovf_d = clip_ovf;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            acc_q <= '0;
            en_q  <= 1'b0;
            dat_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
            en_q  <= en_d;
            dat_q <= dat_d;
            ovf_q <= ovf_d;
        end
    end

    assign data_o_en = en_q;
    assign data_o    = dat_q;
    assign ovf_o     = ovf_q;

endmodule

// File: tb/tb_accumulate_sat_log.sv
// Directed bench for accumulate_sat_log at Q5.20, four taps per frame.
// Expectations follow ACCUM_SAT_EN when it is defined.
module tb_accumulate_sat_log;

    localparam int DW = 25;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          sync_i = 1'b0;
    logic          data_i_en = 1'b0;
    logic [DW-1:0] data_i = '0;
    logic          data_o_en;
    logic [DW-1:0] data_o;
    logic          ovf_o;

    int checks = 0;
    int errors = 0;

    accumulate_sat_log #(
        .width_H(5),
        .width_W(20),
        .tap_num(4)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sync_i   (sync_i),
        .data_i_en(data_i_en),
        .data_i   (data_i),
        .data_o_en(data_o_en),
        .data_o   (data_o),
        .ovf_o    (ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][DW-1:0] taps;
        logic [3:0][1:0]    gaps;
        logic [DW-1:0]      exp_data;
        logic               exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input logic en, input logic sy, input logic [DW-1:0] d);
        data_i_en = en;
        sync_i    = sy;
        data_i    = d;
        @(posedge clk);
        #1;
        data_i_en = 1'b0;
        sync_i    = 1'b0;
        data_i    = '0;
    endtask

    task automatic frame(input string name, input vec_t v);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b0, v.taps[i]);
            if (i < 3) begin
                chk({name, "_en_mid"}, DW'(data_o_en), DW'(0));
                for (int g = 0; g < int'(v.gaps[i]); g++) begin
                    cyc(1'b0, 1'b0, '0);
                    chk({name, "_en_gap"}, DW'(data_o_en), DW'(0));
                end
            end
        end
        chk({name, "_en"}, DW'(data_o_en), DW'(1));
        chk({name, "_data"}, data_o, v.exp_data);
        chk({name, "_ovf"}, DW'(ovf_o), DW'(v.exp_ovf));
        cyc(1'b0, 1'b0, '0);
        chk({name, "_en_drop"}, DW'(data_o_en), DW'(0));
        chk({name, "_ovf_drop"}, DW'(ovf_o), DW'(0));
        chk({name, "_hold"}, data_o, v.exp_data);
    endtask

    initial begin
        vecs[0] = '{taps: {25'h0100000, 25'h0100000, 25'h0100000, 25'h0100000},
                    gaps: '0, exp_data: 25'h0400000, exp_ovf: 1'b0};
        vecs[2] = '{taps: {25'h0080000, 25'h0200000, 25'h1F00000, 25'h0100000},
                    gaps: {2'd0, 2'd3, 2'd1, 2'd2}, exp_data: 25'h0280000, exp_ovf: 1'b0};
        vecs[4] = '{taps: {25'h0, 25'h0, 25'h0, 25'h0FFFFFF},
                    gaps: '0, exp_data: 25'h0FFFFFF, exp_ovf: 1'b0};
        vecs[6] = '{taps: {25'h0, 25'h0, 25'h0, 25'h1000000},
                    gaps: '0, exp_data: 25'h1000000, exp_ovf: 1'b0};
`ifdef ACCUM_SAT_EN
        vecs[1] = '{taps: {4{25'h0800000}}, gaps: '0,
                    exp_data: 25'h0FFFFFF, exp_ovf: 1'b1};
        vecs[3] = '{taps: {4{25'h1800000}}, gaps: '0,
                    exp_data: 25'h1000000, exp_ovf: 1'b1};
        vecs[5] = '{taps: {25'h0, 25'h0, 25'h0000001, 25'h0FFFFFF},
                    gaps: '0, exp_data: 25'h0FFFFFF, exp_ovf: 1'b1};
        vecs[7] = '{taps: {25'h0, 25'h0, 25'h1FFFFFF, 25'h1000000},
                    gaps: '0, exp_data: 25'h1000000, exp_ovf: 1'b1};
`else
        vecs[1] = '{taps: {4{25'h0800000}}, gaps: '0,
                    exp_data: 25'h0000000, exp_ovf: 1'b0};
        vecs[3] = '{taps: {4{25'h1800000}}, gaps: '0,
                    exp_data: 25'h0000000, exp_ovf: 1'b0};
        vecs[5] = '{taps: {25'h0, 25'h0, 25'h0000001, 25'h0FFFFFF},
                    gaps: '0, exp_data: 25'h1000000, exp_ovf: 1'b0};
        vecs[7] = '{taps: {25'h0, 25'h0, 25'h1FFFFFF, 25'h1000000},
                    gaps: '0, exp_data: 25'h0FFFFFF, exp_ovf: 1'b0};
`endif

        repeat (2) @(posedge clk);
        #1;
        chk("rst_en", DW'(data_o_en), DW'(0));
        chk("rst_data", data_o, '0);
        chk("rst_ovf", DW'(ovf_o), DW'(0));
        rst_n = 1'b1;
        cyc(1'b0, 1'b0, '0);

        for (int k = 0; k < 8; k++)
            frame($sformatf("vec%0d", k), vecs[k]);

        // Sync mid-frame restarts the count with the sync sample as tap 0.
        cyc(1'b1, 1'b0, 25'h0100000);
        cyc(1'b1, 1'b0, 25'h0100000);
        cyc(1'b1, 1'b1, 25'h0100000);
        chk("sync_mid_en0", DW'(data_o_en), DW'(0));
        cyc(1'b1, 1'b0, 25'h0100000);
        cyc(1'b1, 1'b0, 25'h0100000);
        chk("sync_mid_en1", DW'(data_o_en), DW'(0));
        cyc(1'b1, 1'b0, 25'h0100000);
        chk("sync_mid_en", DW'(data_o_en), DW'(1));
        chk("sync_mid_data", data_o, 25'h0400000);
        cyc(1'b0, 1'b0, '0);

        // Sync on the final tap cancels that frame's output.
        cyc(1'b1, 1'b0, 25'h0200000);
        cyc(1'b1, 1'b0, 25'h0200000);
        cyc(1'b1, 1'b0, 25'h0200000);
        cyc(1'b1, 1'b1, 25'h0100000);
        chk("sync_last_noen", DW'(data_o_en), DW'(0));
        cyc(1'b1, 1'b0, 25'h0080000);
        cyc(1'b1, 1'b0, 25'h0080000);
        chk("sync_last_en1", DW'(data_o_en), DW'(0));
        cyc(1'b1, 1'b0, 25'h0080000);
        chk("sync_last_en", DW'(data_o_en), DW'(1));
        chk("sync_last_data", data_o, 25'h0280000);
        cyc(1'b0, 1'b0, '0);

        // Async reset mid-frame clears outputs and the partial sum.
        cyc(1'b1, 1'b0, 25'h0100000);
        cyc(1'b1, 1'b0, 25'h0100000);
        cyc(1'b1, 1'b0, 25'h0100000);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_data", data_o, '0);
        chk("arst_en", DW'(data_o_en), DW'(0));
        chk("arst_ovf", DW'(ovf_o), DW'(0));
        cyc(1'b1, 1'b0, 25'h0100000);
        chk("arst_hold_en", DW'(data_o_en), DW'(0));
        rst_n = 1'b1;
        frame("post_rst", vecs[0]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
